// File: rtl/jtopl_kon_sched.sv
// Key-on scheduler: per-channel key-on requests serialized onto the slot rotation,
// committed at frame boundaries. Optional CSM key-on burst under `JTOPL_CSM_EN.
module jtopl_kon_sched #(
  parameter int unsigned SLOTS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cenop,
  input  logic       wr_en,
  input  logic [3:0] wr_ch,
  input  logic       wr_kon,
  input  logic       csm_en,
  input  logic       csm_trig,
  output logic [4:0] slot,
  output logic       zero,
  output logic       keyon_I,
  output logic [8:0] kon_st
);

  localparam int unsigned NCH = SLOTS / 2;
  localparam int unsigned SW  = 5;
  localparam int unsigned CW  = 4;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ON     = 2'd1,
    ST_RETRIG = 2'd2
  } ch_st_e;

  logic [SW-1:0]  slot_q, slot_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] offseen_q, offseen_d;
  ch_st_e         st_q [NCH];
  ch_st_e         st_d [NCH];
  logic [NCH-1:0] out_kon_c;
  logic           commit_c;
  logic           csm_act_c;
  logic [SW-1:0]  grp_c, pos_c;
  logic [CW-1:0]  ch_c;

  assign commit_c = cenop && (slot_q == LAST_SLOT);

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) out_kon_c[i] = (st_q[i] == ST_ON);
  end

  // Next-state: slot rotation, per-channel commit FSM, CPU write path
  always_comb begin
    slot_d    = slot_q;
    pend_d    = pend_q;
    offseen_d = offseen_q;
    st_d      = st_q;
    if (cenop) slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
    if (commit_c) begin
      offseen_d = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        case (st_q[i])
          ST_OFF:    if (pend_q[i]) st_d[i] = ST_ON;
          ST_ON: begin
            if (!pend_q[i])        st_d[i] = ST_OFF;
            else if (offseen_q[i]) st_d[i] = ST_RETRIG;
          end
          ST_RETRIG: st_d[i] = pend_q[i] ? ST_ON : ST_OFF;
          default:   st_d[i] = ST_OFF;
        endcase
      end
    end
    // A write on the commit edge lands after the commit, so it is applied last
    if (wr_en && (wr_ch <= LAST_CH)) begin
      if (pend_q[wr_ch] && !wr_kon && out_kon_c[wr_ch]) offseen_d[wr_ch] = 1'b1;
      pend_d[wr_ch] = wr_kon;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      pend_q    <= '0;
      offseen_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) st_q[i] <= ST_OFF;
    end else begin
      slot_q    <= slot_d;
      pend_q    <= pend_d;
      offseen_q <= offseen_d;
      st_q      <= st_d;
    end
  end

`ifdef JTOPL_CSM_EN
  logic csm_pend_q, csm_pend_d, csm_act_q, csm_act_d;

  // CSM: a trigger arms one all-channel key-on frame starting at the next commit
  always_comb begin
    csm_pend_d = csm_pend_q;
    csm_act_d  = csm_act_q;
    if (commit_c) begin
      csm_act_d  = csm_pend_q;
      csm_pend_d = 1'b0;
    end
    if (csm_en && csm_trig) csm_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csm_pend_q <= 1'b0;
      csm_act_q  <= 1'b0;
    end else begin
      csm_pend_q <= csm_pend_d;
      csm_act_q  <= csm_act_d;
    end
  end

  assign csm_act_c = csm_act_q;
`else
  logic csm_unused;
  assign csm_unused = ^{csm_en, csm_trig};
  assign csm_act_c  = 1'b0;
`endif

  // Slot to channel: three channels per six-slot group, op1 then op2
  always_comb begin
    grp_c = slot_q / SW'(6);
    pos_c = slot_q % SW'(3);
    ch_c  = CW'(grp_c * SW'(3) + pos_c);
  end

  assign slot    = slot_q;
  assign zero    = (slot_q == '0);
  assign keyon_I = out_kon_c[ch_c] | csm_act_c;
  assign kon_st  = out_kon_c;

endmodule

// File: tb/tb_jtopl_kon_sched.sv
// Bench for jtopl_kon_sched: directed frames plus random traffic against a frame-level model.
module tb_jtopl_kon_sched;

  logic       clk, rst_n, cenop, wr_en, wr_kon, csm_en, csm_trig;
  logic [3:0] wr_ch;
  logic [4:0] slot;
  logic       zero, keyon_I;
  logic [8:0] kon_st;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: requested value, "released this frame" flag, committed key-on
  int       m_slot;
  logic [8:0] m_pend, m_rel, m_kon;
  logic     m_cpend, m_act;

  jtopl_kon_sched dut (
    .clk(clk), .rst_n(rst_n), .cenop(cenop), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_kon(wr_kon), .csm_en(csm_en), .csm_trig(csm_trig),
    .slot(slot), .zero(zero), .keyon_I(keyon_I), .kon_st(kon_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, m_slot, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_pend = '0; m_rel = '0; m_kon = '0; m_cpend = 1'b0; m_act = 1'b0;
  endtask

  task automatic check_outputs();
    int ec;
    ec = (m_slot / 6) * 3 + (m_slot % 3);
    chk("slot", 32'(slot), 32'(m_slot));
    chk("zero", 32'(zero), 32'(m_slot == 0));
    chk("keyon_I", 32'(keyon_I), 32'(m_kon[ec] | m_act));
    chk("kon_st", 32'(kon_st), 32'(m_kon));
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later
  task automatic step(input logic cen, input logic we, input logic [3:0] ch,
                      input logic kon, input logic trig);
    logic [8:0] old_kon;
    cenop = cen; wr_en = we; wr_ch = ch; wr_kon = kon; csm_trig = trig;
    @(posedge clk);
    old_kon = m_kon;
    if (cen && m_slot == 17) begin
      for (int c = 0; c < 9; c++) m_kon[c] = m_pend[c] && !(old_kon[c] && m_rel[c]);
      m_rel = '0;
`ifdef JTOPL_CSM_EN
      m_act = m_cpend; m_cpend = 1'b0;
`endif
    end
    if (we && ch < 4'd9) begin
      if (m_pend[ch] && !kon && old_kon[ch]) m_rel[ch] = 1'b1;
      m_pend[ch] = kon;
    end
`ifdef JTOPL_CSM_EN
    if (trig && csm_en) m_cpend = 1'b1;
`endif
    if (cen) m_slot = (m_slot + 1) % 18;
    #1;
    check_outputs();
    wr_en = 1'b0; csm_trig = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic to_slot(input int n);
    for (int i = 0; i < 18 && m_slot != n; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] ch, input logic kon);
    step(1'b1, 1'b1, ch, kon, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cenop = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_kon = 1'b0;
    csm_en = 1'b0; csm_trig = 1'b0;
    model_reset();
    #2;
    check_outputs();
    #10 rst_n = 1'b1;

    // Free-running rotation, two wraps
    idle(40);

    // Key-on ch4 mid-frame; visible only after the commit
    to_slot(5);
    wr(4'd4, 1'b1);
    to_slot(0);
    chk("kon_st_ch4_on", 32'(kon_st), 32'h010);
    idle(18);

    // Release and re-key inside one frame forces a key-off frame
    to_slot(3);
    wr(4'd4, 1'b0);
    wr(4'd4, 1'b1);
    to_slot(0);
    chk("kon_st_retrig_off", 32'(kon_st), 32'h000);
    idle(18);
    chk("kon_st_retrig_on", 32'(kon_st), 32'h010);

    // Out-of-range channel is ignored
    wr(4'd12, 1'b1);
    idle(54);

    // Write on the commit edge takes effect one frame later
    to_slot(17);
    wr(4'd0, 1'b1);
    chk("kon_st_commit_edge", 32'(kon_st), 32'h010);
    idle(18);
    chk("kon_st_ch0_late", 32'(kon_st), 32'h011);

    // Gaps in cenop hold the rotation
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Clear all channels, then a CSM trigger mid-frame
    for (int c = 0; c < 9; c++) wr(4'(c), 1'b0);
    to_slot(0);
    idle(18);
    csm_en = 1'b1;
    to_slot(8);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    to_slot(0);
    idle(36);
    csm_en = 1'b0;
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    to_slot(0);
    idle(18);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) csm_en = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 60) == 0);
    end

    // Asynchronous reset mid-frame
    to_slot(9);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
